// File: rtl/player_ctrl_pkg.sv
// Shared definitions for the player sprite: motion-state encoding, screen geometry
// and default motion constants used by player_ctrl and the sprite drawing logic.
package player_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_JUMP = 2'd2,
      ST_FALL = 2'd3
   } motion_state_e;

   localparam int XRES           = 640;
   localparam int YRES           = 480;
   localparam int PLAYER_WIDTH   = 40;

   localparam int WALK_SPEED_DEF = 2;
   localparam int JUMP_V0_DEF    = 12;
   localparam int GRAVITY_DEF    = 1;
   localparam int VMAX_FALL_DEF  = 8;
   localparam int X_MAX_DEF      = 600;
   localparam int Y_MAX_DEF      = 400;

   // Ground-level state a player settles into when not starting a jump.
   function automatic motion_state_e ground_state(input logic left, input logic right);
      return (left ^ right) ? ST_WALK : ST_IDLE;
   endfunction

endpackage

// File: rtl/player_ctrl_frame_tick.sv
// Frame tick generator: one-cycle strobe on the rising edge of vsync_in.
module frame_tick (
   input  logic clk,
   input  logic rst,
   input  logic vsync_in,
   output logic tick
);

   logic vsync_q;
   logic vsync_d;

   always_comb begin
      vsync_d = vsync_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vsync_q <= 1'b0;
      end else begin
         vsync_q <= vsync_d;
      end
   end

   assign tick = vsync_in & ~vsync_q;

endmodule

// File: rtl/player_ctrl.sv
// Player motion controller: walking, jumping and falling updated once per frame,
// plus power-up size tracking. Defining PLAYER_RUN_EN adds a btn_run input that doubles the walk step.
module player_ctrl
   import player_ctrl_pkg::*;
#(
   parameter int WALK_SPEED = WALK_SPEED_DEF,
   parameter int JUMP_V0    = JUMP_V0_DEF,
   parameter int GRAVITY    = GRAVITY_DEF,
   parameter int VMAX_FALL  = VMAX_FALL_DEF,
   parameter int X_MAX      = X_MAX_DEF,
   parameter int Y_MAX      = Y_MAX_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vsync_in,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_jump,
`ifdef PLAYER_RUN_EN
   input  logic       btn_run,
`endif
   input  logic       grow,
   input  logic       hit,
   output logic [9:0] xpos,
   output logic [8:0] ypos,
   output logic       direction,
   output logic       size,
   output logic [1:0] state
);

   logic          tick;
   logic [9:0]    xpos_q, xpos_d;
   logic [8:0]    ypos_q, ypos_d;
   logic          dir_q, dir_d;
   logic          size_q, size_d;
   motion_state_e state_q, state_d;
   logic [4:0]    vy_q, vy_d;
   logic [4:0]    vf_q, vf_d;

   logic [10:0]   step;
   logic [10:0]   xsum;
   logic [9:0]    ysum;
   logic [5:0]    vf_sum;
   logic [4:0]    vf_new;
   logic [4:0]    vy_next;

   frame_tick u_frame_tick (
      .clk      (clk),
      .rst      (rst),
      .vsync_in (vsync_in),
      .tick     (tick)
   );

`ifdef PLAYER_RUN_EN
   assign step = btn_run ? 11'(2 * WALK_SPEED) : 11'(WALK_SPEED);
`else
   assign step = 11'(WALK_SPEED);
`endif

   always_comb begin
      xpos_d  = xpos_q;
      ypos_d  = ypos_q;
      dir_d   = dir_q;
      size_d  = size_q;
      state_d = state_q;
      vy_d    = vy_q;
      vf_d    = vf_q;
      xsum    = {1'b0, xpos_q} + step;
      ysum    = {1'b0, ypos_q} + {5'd0, vy_q};
      vf_sum  = {1'b0, vf_q} + 6'(GRAVITY);
      vf_new  = (vf_sum > 6'(VMAX_FALL)) ? 5'(VMAX_FALL) : vf_sum[4:0];
      vy_next = (vy_q > 5'(GRAVITY)) ? (vy_q - 5'(GRAVITY)) : 5'd0;

      if (tick) begin
         if (btn_left && !btn_right) begin
            dir_d  = 1'b1;
            xpos_d = ({1'b0, xpos_q} < step) ? 10'd0 : (xpos_q - step[9:0]);
         end else if (btn_right && !btn_left) begin
            dir_d  = 1'b0;
            xpos_d = (xsum > 11'(X_MAX)) ? 10'(X_MAX) : xsum[9:0];
         end

         case (state_q)
            ST_IDLE, ST_WALK: begin
               if (btn_jump) begin
                  state_d = ST_JUMP;
                  vy_d    = 5'(JUMP_V0);
               end else begin
                  state_d = ground_state(btn_left, btn_right);
               end
            end
            ST_JUMP: begin
               ypos_d = (ysum > 10'(Y_MAX)) ? 9'(Y_MAX) : ysum[8:0];
               vy_d   = vy_next;
               if (vy_next == 5'd0) begin
                  state_d = ST_FALL;
                  vf_d    = 5'd0;
               end
            end
            ST_FALL: begin
               vf_d = vf_new;
               // Landing tick never starts a jump even with btn_jump held.
               if (ypos_q <= {4'd0, vf_new}) begin
                  ypos_d  = 9'd0;
                  state_d = ground_state(btn_left, btn_right);
               end else begin
                  ypos_d = ypos_q - {4'd0, vf_new};
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (hit) begin
         size_d = 1'b0;
      end else if (grow) begin
         size_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xpos_q  <= 10'd0;
         ypos_q  <= 9'd0;
         dir_q   <= 1'b0;
         size_q  <= 1'b0;
         state_q <= ST_IDLE;
         vy_q    <= 5'd0;
         vf_q    <= 5'd0;
      end else begin
         xpos_q  <= xpos_d;
         ypos_q  <= ypos_d;
         dir_q   <= dir_d;
         size_q  <= size_d;
         state_q <= state_d;
         vy_q    <= vy_d;
         vf_q    <= vf_d;
      end
   end

   assign xpos      = xpos_q;
   assign ypos      = ypos_q;
   assign direction = dir_q;
   assign size      = size_q;
   assign state     = state_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: expected outputs are queued when a frame
// or pulse is driven and compared once the DUT has updated.
module tb_player_ctrl;
   import player_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       vsync_in;
   logic       btn_left;
   logic       btn_right;
   logic       btn_jump;
   logic       btn_run;
   logic       grow;
   logic       hit;
   logic [9:0] xpos;
   logic [8:0] ypos;
   logic       direction;
   logic       size;
   logic [1:0] state;

   player_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .vsync_in  (vsync_in),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_jump  (btn_jump),
`ifdef PLAYER_RUN_EN
      .btn_run   (btn_run),
`endif
      .grow      (grow),
      .hit       (hit),
      .xpos      (xpos),
      .ypos      (ypos),
      .direction (direction),
      .size      (size),
      .state     (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      string tag;
      int    x;
      int    y;
      int    d;
      int    s;
      int    st;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   expSize = 0;
   int   lastX = 0;
   int   lastY = 0;
   int   lastD = 0;
   int   lastSt = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic pushExp(input string tag, input int x, input int y, input int d, input int st);
      exp_t e;
      e.tag = tag;
      e.x   = x;
      e.y   = y;
      e.d   = d;
      e.s   = expSize;
      e.st  = st;
      sbq.push_back(e);
      lastX  = x;
      lastY  = y;
      lastD  = d;
      lastSt = st;
   endtask

   task automatic popCompare();
      exp_t e;
      checkOutput("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         checkOutput({e.tag, ".xpos"},  32'(xpos),      32'(e.x));
         checkOutput({e.tag, ".ypos"},  32'(ypos),      32'(e.y));
         checkOutput({e.tag, ".dir"},   32'(direction), 32'(e.d));
         checkOutput({e.tag, ".size"},  32'(size),      32'(e.s));
         checkOutput({e.tag, ".state"}, 32'(state),     32'(e.st));
      end
   endtask

   // One frame: vsync high for one cycle with buttons set, then compare.
   task automatic applyStimulus(input logic l, input logic r, input logic j, input logic run,
                                input string tag, input int x, input int y, input int d, input int st);
      @(negedge clk);
      btn_left  = l;
      btn_right = r;
      btn_jump  = j;
      btn_run   = run;
      vsync_in  = 1'b1;
      pushExp(tag, x, y, d, st);
      @(negedge clk);
      vsync_in = 1'b0;
      popCompare();
      @(negedge clk);
   endtask

   task automatic sizePulse(input logic g, input logic h, input string tag);
      @(negedge clk);
      grow = g;
      hit  = h;
      if (h) expSize = 0;
      else if (g) expSize = 1;
      pushExp(tag, lastX, lastY, lastD, lastSt);
      @(negedge clk);
      grow = 1'b0;
      hit  = 1'b0;
      popCompare();
   endtask

   int jy[12] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78};
   int fy[14] = '{77, 75, 72, 68, 63, 57, 50, 42, 34, 26, 18, 10, 2, 0};

   initial begin
      rst       = 1'b0;
      vsync_in  = 1'b0;
      btn_left  = 1'b0;
      btn_right = 1'b0;
      btn_jump  = 1'b0;
      btn_run   = 1'b0;
      grow      = 1'b0;
      hit       = 1'b0;

      repeat (3) @(negedge clk);
      pushExp("reset", 0, 0, 0, ST_IDLE);
      popCompare();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "right1", 2, 0, 0, ST_WALK);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "right2", 4, 0, 0, ST_WALK);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "right3", 6, 0, 0, ST_WALK);

      // Buttons held between frames must not move the player.
      @(negedge clk);
      btn_right = 1'b1;
      repeat (6) @(negedge clk);
      pushExp("no_tick", 6, 0, 0, ST_WALK);
      popCompare();

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "neither", 6, 0, 0, ST_IDLE);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "both",    6, 0, 0, ST_IDLE);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "left1",   4, 0, 1, ST_WALK);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "left2",   2, 0, 1, ST_WALK);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "left_sat1", 0, 0, 1, ST_WALK);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "left_sat2", 0, 0, 1, ST_WALK);

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "jump_start", 0, 0, 1, ST_JUMP);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, $sformatf("jump_up%0d", i), 0, jy[i], 1,
                       (i == 11) ? int'(ST_FALL) : int'(ST_JUMP));
      end
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, $sformatf("fall%0d", i), 0, fy[i], 1, ST_FALL);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "fall12", 2, fy[12], 0, ST_FALL);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, "land",   4, fy[13], 0, ST_WALK);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "settle", 4, 0, 0, ST_IDLE);

      sizePulse(1'b1, 1'b0, "grow1");
      sizePulse(1'b1, 1'b0, "grow_big");
      sizePulse(1'b1, 1'b1, "grow_hit");
      sizePulse(1'b0, 1'b1, "hit_small");
      sizePulse(1'b1, 1'b0, "grow2");

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "j2_start", 4, 0, 0, ST_JUMP);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("j2_up%0d", i), 4, jy[i], 0, ST_JUMP);
      end

      // Asynchronous reset between clock edges while airborne at ypos 50.
      @(negedge clk);
      #2;
      rst = 1'b0;
      expSize = 0;
      #1;
      pushExp("async_rst", 0, 0, 0, ST_IDLE);
      popCompare();
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "post_rst", 0, 0, 0, ST_IDLE);

`ifdef PLAYER_RUN_EN
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "run1", 4, 0, 0, ST_WALK);
      for (int i = 2; i <= 151; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, $sformatf("run%0d", i),
                       (4 * i > 600) ? 600 : 4 * i, 0, 0, ST_WALK);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "run_sat", 600, 0, 0, ST_WALK);
`else
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "run_ignored", 2, 0, 0, ST_WALK);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
